// File: rtl/taitosj_snd_pkg.sv
// Shared constants, status-byte layout and IRQ scheduler state for the TaitoSJ sound control block.
// Addresses are full 16-bit sound-CPU addresses; the counter is wide enough for the default period.
package taitosj_snd_pkg;

  localparam logic [15:0] CMD_ADDR       = 16'h5000;
  localparam logic [15:0] STAT_ADDR      = 16'h5001;
  localparam int unsigned IRQ_PERIOD_DEF = 40961;
  localparam int          CNT_W          = 16;

  localparam logic [3:0]  STAT_HI = 4'hF;
  localparam logic [1:0]  STAT_LO = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

  function automatic logic [7:0] stat_byte(input logic pending, input logic flag);
    return {STAT_HI, pending, flag, STAT_LO};
  endfunction

endpackage

// File: rtl/taitosj_snd_irq_timer.sv
// Periodic maskable-IRQ scheduler: tick counter, IDLE/REQ FSM and acknowledge falling-edge detector.
// IRQ output falls one clock after the wrapping tick and rises one clock after the acknowledge edge.
module snd_irq_timer
  import taitosj_snd_pkg::*;
#(
  parameter int unsigned IRQ_PERIOD = IRQ_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ce,
  input  logic i_pause,
  input  logic i_m1_n,
  input  logic i_iorq_n,
  output logic o_irq_n
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_irq_n;
  irq_state_e       r_state;
  irq_state_e       w_state_nxt;
  logic             w_ack;
  logic             w_tick;
  logic             w_wrap;
  logic             w_ack_fall;

  assign w_ack      = ~i_m1_n & ~i_iorq_n;
  assign w_tick     = i_ce & ~i_pause;
  assign w_wrap     = w_tick & (r_cnt == CNT_W'(IRQ_PERIOD - 1));
  // end of the interrupt-acknowledge cycle: previous sample active, current one not
  assign w_ack_fall = r_ack & ~w_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_state <= IDLE;
      r_irq_n <= 1'b1;
    end else begin
      r_ack   <= w_ack;
      r_state <= w_state_nxt;
      r_irq_n <= (r_state != REQ);
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // a wrap that lands together with an acknowledge is dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_wrap && !w_ack_fall) w_state_nxt = REQ;
      REQ:     if (w_ack_fall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_irq_n = r_irq_n;

endmodule

// File: rtl/taitosj_snd_ctrl.sv
// Sound-CPU mailbox: command latch, pending/flag semaphores, NMI generation, read mux and IRQ timer.
// Bus strobes are sampled once; read data appears one clock after the sample, status/NMI one clock after cause.
module taitosj_snd_ctrl
  import taitosj_snd_pkg::*;
#(
  parameter int unsigned IRQ_PERIOD = IRQ_PERIOD_DEF
) (
  input  logic        clkm_48MHZ,
  input  logic        nSND_RST,
  input  logic        ce_1p5,
  input  logic        pause,
  input  logic        main_cmd_wr,
  input  logic        main_flag_wr,
  input  logic [7:0]  main_din,
  output logic [1:0]  main_stat,
  input  logic [15:0] snd_addr,
  input  logic        snd_rd_n,
  input  logic        snd_wr_n,
  input  logic        snd_m1_n,
  input  logic        snd_iorq_n,
  input  logic        nmi_mask,
  output logic [7:0]  snd_din,
  output logic        snd_din_en,
  output logic        snd_irq_n,
  output logic        snd_nmi_n
);

  logic [15:0] r_addr;
  logic        r_rd_n;
  logic        r_wr_n;
  logic [7:0]  r_cmd;
  logic        r_pend;
  logic        r_flag;
  logic [7:0]  r_din;
  logic        r_din_en;
  logic        r_nmi_n;

  logic        w_cmd_rd;
  logic        w_stat_rd;
  logic        w_pend_clr;
  logic        w_flag_clr;

  assign w_cmd_rd   = ~r_rd_n & (r_addr == CMD_ADDR);
  assign w_stat_rd  = ~r_rd_n & (r_addr == STAT_ADDR);
  // rd_n seen rising after a sampled command read: exactly one clear per access
  assign w_pend_clr = w_cmd_rd & snd_rd_n;
  assign w_flag_clr = r_wr_n & ~snd_wr_n & (snd_addr == STAT_ADDR);

  always_ff @(posedge clkm_48MHZ or negedge nSND_RST) begin
    if (!nSND_RST) begin
      r_addr   <= '0;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_cmd    <= '0;
      r_pend   <= 1'b0;
      r_flag   <= 1'b0;
      r_din    <= '0;
      r_din_en <= 1'b0;
      r_nmi_n  <= 1'b1;
    end else begin
      r_addr <= snd_addr;
      r_rd_n <= snd_rd_n;
      r_wr_n <= snd_wr_n;

      // main-CPU writes take priority over sound-side clears
      if (main_cmd_wr) begin
        r_cmd  <= main_din;
        r_pend <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end

      if (main_flag_wr) begin
        r_flag <= main_din[0];
      end else if (w_flag_clr) begin
        r_flag <= 1'b0;
      end

      r_nmi_n  <= ~((r_pend & ~nmi_mask) | r_flag);
      r_din_en <= w_cmd_rd | w_stat_rd;
      if (w_cmd_rd) begin
        r_din <= r_cmd;
      end else if (w_stat_rd) begin
        r_din <= stat_byte(r_pend, r_flag);
      end else begin
        r_din <= '0;
      end
    end
  end

  snd_irq_timer #(
    .IRQ_PERIOD (IRQ_PERIOD)
  ) u_irq_timer (
    .i_clk    (clkm_48MHZ),
    .i_rst_n  (nSND_RST),
    .i_ce     (ce_1p5),
    .i_pause  (pause),
    .i_m1_n   (snd_m1_n),
    .i_iorq_n (snd_iorq_n),
    .o_irq_n  (snd_irq_n)
  );

  assign main_stat  = {r_pend, r_flag};
  assign snd_din    = r_din;
  assign snd_din_en = r_din_en;
  assign snd_nmi_n  = r_nmi_n;

endmodule

// File: doc/taitosj_snd_ctrl.md
# taitosj_snd_ctrl

Sound-CPU control and mailbox block for the TaitoSJ audio subsystem. It sits between the main CPU's sound-command port strobes and the audio Z80. It owns four things: the 8-bit command latch, the pending and flag semaphores, the NMI request logic, and the periodic maskable-IRQ scheduler with interrupt-acknowledge clearing. It replaces the ad-hoc, edge-clocked latch and interrupt logic with one fully synchronous block on the master clock.

## Interface
- IRQ_PERIOD, 40961, number of `ce_1p5` ticks between IRQ requests.
- CMD_ADDR, 16'h5000, sound-CPU address of the command latch.
- STAT_ADDR, 16'h5001, sound-CPU address of the status/flag port.

- clkm_48MHZ  in  1  master clock; all state updates on rising edge.
- nSND_RST  in  1  reset, asynchronous assert, active-low.
- ce_1p5  in  1  single-cycle IRQ timebase enable.
- pause  in  1  freezes the IRQ counter.
- main_cmd_wr  in  1  single-cycle strobe: load `main_din` into the command latch.
- main_flag_wr  in  1  single-cycle strobe: load `main_din[0]` into the flag.
- main_din  in  8  main-CPU data.
- main_stat  out  2  {pending, flag}, for main-CPU polling.
- snd_addr  in  16  sound-CPU address bus.
- snd_rd_n, snd_wr_n, snd_m1_n, snd_iorq_n  in  1 each  sound-CPU bus strobes.
- nmi_mask  in  1  NMI gate for pending; driven from AY3 IOB[0].
- snd_din  out  8  read data toward the sound CPU.
- snd_din_en  out  1  high while `snd_din` must win the sound-CPU read mux.
- snd_irq_n  out  1  maskable interrupt, active-low.
- snd_nmi_n  out  1  non-maskable interrupt, active-low.

## Operation
- **Reset values:** cmd_data=0, pending=0, flag=0, counter=0, irq state IDLE, snd_irq_n=1, snd_nmi_n=1, snd_din=0, snd_din_en=0.
- **Command write:** `main_cmd_wr` sets cmd_data←main_din and pending←1.
- **Flag write:** `main_flag_wr` sets flag←main_din[0].
- **Sound-CPU read of CMD_ADDR:** returns cmd_data. Pending clears on the rising edge of `snd_rd_n` (end of the read), once per access.
- **Sound-CPU read of STAT_ADDR:** returns {4'hF, pending, flag, 2'b11}.
- **Sound-CPU write to STAT_ADDR:** clears flag on the falling edge of `snd_wr_n`; the data is ignored.
- **Simultaneous events:**
  - `main_cmd_wr` in the same cycle as a pending-clear: the write wins, so pending=1 and data is new.
  - `main_flag_wr` in the same cycle as a STAT write clear: the main write wins.
- **NMI:** snd_nmi_n = !((pending & !nmi_mask) | flag). The output is registered and level-sensitive.
- **IRQ scheduler:**
  - States: IDLE, REQ.
  - Counter: advances on each `ce_1p5` while !pause, counting 0..IRQ_PERIOD-1 and then wrapping.
  - Wrap in IDLE moves to REQ.
  - REQ drives snd_irq_n=0.
  - Acknowledge: the falling edge of (!snd_m1_n & !snd_iorq_n) moves REQ to IDLE.
  - A wrap while in REQ is absorbed; there is no queueing and the FSM stays in REQ.
  - A wrap and an acknowledge in the same cycle end in IDLE; the new request is dropped.
- **Read mux:**
  - snd_din_en=1 when !snd_rd_n and snd_addr ∈ {CMD_ADDR, STAT_ADDR}; otherwise 0.
  - When snd_din_en=0, snd_din=0.

## Timing
- All bus strobes are sampled into one register stage. Edge detection compares the current and previous sample.
- Read-data latency: `snd_din` and `snd_din_en` are valid 1 clock after the address and `snd_rd_n` are sampled. The sound CPU samples at 3 MHz, giving at least 15 clocks of margin.
- `main_stat` and `snd_nmi_n` update 1 clock after the causing event.
- `snd_irq_n` falls 1 clock after the wrap tick and rises 1 clock after the acknowledge edge is detected.
- `pause`:
  - Blocks counter advance only.
  - While `pause` is high the FSM still accepts acknowledges and holds REQ; the latches keep working.
- Reset mid-operation returns everything to reset values immediately and asynchronously. The counter restarts from 0 after release.

## Structure
- Package `taitosj_snd_pkg` holds:
  - CMD_ADDR and STAT_ADDR.
  - The default IRQ_PERIOD.
  - The status constant bits (4'hF, 2'b11).
  - The IRQ state enum {IDLE, REQ}.
- Sub-module `snd_irq_timer`: counter, FSM and acknowledge edge detector.
- The mailbox, NMI logic and read mux live in the top level.

## Test plan
- **Command round-trip:**
  - Stimulus: main_cmd_wr with 8'hA5, then a sound read of 16'h5000.
  - Required: snd_din=8'hA5, snd_din_en=1. During the read, main_stat[1] is still 1 and reads of 16'h5001 return 8'hFB. Once snd_rd_n rises, main_stat[1] falls.
- **NMI gating:**
  - Command pending with nmi_mask=1 → snd_nmi_n=1.
  - Drop nmi_mask to 0 → snd_nmi_n=0 within 1 clock.
  - main_flag_wr with din=1 → snd_nmi_n=0 regardless of mask.
  - Sound write to 16'h5001 → flag=0.
- **IRQ period:**
  - Stimulus: IRQ_PERIOD=16 and ce_1p5 held high every cycle.
  - Required: snd_irq_n falls at clock 17 after reset release. It stays low through 40 further clocks with no acknowledge.
  - An M1+IORQ pulse releases it; the next fall is 16 ticks after the previous wrap.
- **Collision:**
  - Stimulus: main_cmd_wr with 8'h3C in the same clock as snd_rd_n rising at 16'h5000.
  - Required: pending=1 and a re-read returns 8'h3C.
- **Pause and reset:**
  - Assert pause for 100 ticks → counter frozen and no new IRQ. Release → the period resumes from the frozen count.
  - Pulse nSND_RST low with REQ active and pending=1 → all outputs return to reset values in the same cycle.
